// File: rtl/dec_sched_pkg.sv
// Shared types and widths for the ADPCM decoder channel scheduler.
// Holds the FSM state encoding and the code and sample widths.
package dec_sched_pkg;

   localparam int CODE_W   = 4;
   localparam int SAMPLE_W = 16;
   localparam int NCH_DEF  = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

endpackage

// File: rtl/dec_rr_arb.sv
// Rotating-priority encoder: the first pending channel after 'last', wrapping at NCH.
// Purely combinational, no backpressure.
module dec_rr_arb #(
   parameter int NCH = 32,
   parameter int CW  = $clog2(NCH)
) (
   input  logic [NCH-1:0] pending,
   input  logic [CW-1:0]  last,
   output logic [CW-1:0]  grant_idx,
   output logic           grant_vld
);

   logic [CW-1:0] idx;

   always_comb begin
      grant_idx = '0;
      grant_vld = 1'b0;
      idx       = last;
      for (int i = 0; i < NCH; i++) begin
         idx = (idx == CW'(NCH - 1)) ? '0 : idx + CW'(1);
         if (!grant_vld && pending[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
      end
   end

endmodule

// File: rtl/dec_sched.sv
// Round-robin scheduler sharing one ADPCM decoder among NCH channels; optional WAIT abort with DEC_SCHED_TIMEOUT_EN.
// Write to dec_start is 2 cycles, dec_done to out_valid is 1 cycle; a rewrite of a pending channel overwrites it and pulses overrun.
module dec_sched
   import dec_sched_pkg::*;
#(
   parameter int NCH     = NCH_DEF,
   parameter int CW      = $clog2(NCH),
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ch_wr,
   input  logic [CW-1:0]       ch_idx,
   input  logic [CODE_W-1:0]   ch_code,
   output logic                dec_start,
   output logic [CW-1:0]       dec_chan,
   output logic [CODE_W-1:0]   dec_code,
   input  logic                dec_done,
   input  logic [SAMPLE_W-1:0] dec_sr,
   output logic                out_valid,
   output logic [CW-1:0]       out_chan,
   output logic [SAMPLE_W-1:0] out_data,
   output logic                overrun,
   output logic                busy,
   output logic                timeout_err
);

   localparam logic [CW:0] NCH_L = (CW + 1)'(NCH);

   state_t            state, state_nxt;
   logic [NCH-1:0]    pending;
   logic [CODE_W-1:0] code_mem [NCH];
   logic [CW-1:0]     last;
   logic [CW-1:0]     grant_idx;
   logic              grant_vld;
   logic              wr_ok;
   logic              capture;
   logic              finish;
   logic              abort;

   assign wr_ok   = ch_wr && ({1'b0, ch_idx} < NCH_L);
   assign capture = (state == S_IDLE) && grant_vld;
   assign finish  = (state == S_WAIT) && dec_done;

   dec_rr_arb #(
      .NCH (NCH),
      .CW  (CW)
   ) u_arb (
      .pending   (pending),
      .last      (last),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

`ifdef DEC_SCHED_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

   logic [TW-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (reset || state != S_WAIT) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + TW'(1);
      end
   end

   // WAIT lasts at most TIMEOUT cycles; a done in the last cycle still wins
   assign abort = (state == S_WAIT) && !dec_done && (wait_cnt == TW'(TIMEOUT - 1));
`else
   // Never true for a legal TIMEOUT, so WAIT has no bound in this build
   assign abort = (TIMEOUT < 0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      dec_start   = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      timeout_err = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (grant_vld) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            dec_start = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (dec_done) begin
               state_nxt = S_DONE;
            end else if (abort) begin
               timeout_err = 1'b1;
               state_nxt   = S_IDLE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // The write follows the capture clear so a same-cycle write to the granted channel re-pends it
   always_ff @(posedge clk) begin
      if (reset) begin
         pending  <= '0;
         for (int i = 0; i < NCH; i++) begin
            code_mem[i] <= '0;
         end
         last     <= CW'(NCH - 1);
         dec_chan <= '0;
         dec_code <= '0;
         out_chan <= '0;
         out_data <= '0;
         overrun  <= 1'b0;
      end else begin
         overrun <= wr_ok && pending[ch_idx] && !(capture && (ch_idx == grant_idx));
         if (capture) begin
            pending[grant_idx] <= 1'b0;
            last               <= grant_idx;
            dec_chan           <= grant_idx;
            dec_code           <= code_mem[grant_idx];
         end
         if (wr_ok) begin
            pending[ch_idx]  <= 1'b1;
            code_mem[ch_idx] <= ch_code;
         end
         if (finish) begin
            out_chan <= dec_chan;
            out_data <= dec_sr;
         end
      end
   end

endmodule

// File: tb/tb_dec_sched.sv
// Self-checking bench for dec_sched: a vector table of single transactions plus hand-written
// multi-cycle sequences; results are predicted into a scoreboard queue and popped on out_valid.
`timescale 1ns/1ps
module tb_dec_sched;
   import dec_sched_pkg::*;

   localparam int NCH = 32;
   localparam int CW  = 5;

   logic                clk = 1'b0;
   logic                reset;
   logic                ch_wr;
   logic [CW-1:0]       ch_idx;
   logic [CODE_W-1:0]   ch_code;
   logic                dec_start;
   logic [CW-1:0]       dec_chan;
   logic [CODE_W-1:0]   dec_code;
   logic                dec_done;
   logic [SAMPLE_W-1:0] dec_sr;
   logic                out_valid;
   logic [CW-1:0]       out_chan;
   logic [SAMPLE_W-1:0] out_data;
   logic                overrun;
   logic                busy;
   logic                timeout_err;

   always #5 clk = ~clk;

   dec_sched #(
      .NCH     (NCH),
      .CW      (CW),
      .TIMEOUT (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ch_wr       (ch_wr),
      .ch_idx      (ch_idx),
      .ch_code     (ch_code),
      .dec_start   (dec_start),
      .dec_chan    (dec_chan),
      .dec_code    (dec_code),
      .dec_done    (dec_done),
      .dec_sr      (dec_sr),
      .out_valid   (out_valid),
      .out_chan    (out_chan),
      .out_data    (out_data),
      .overrun     (overrun),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   typedef struct packed {
      logic [CW-1:0]       ch;
      logic [SAMPLE_W-1:0] sr;
   } exp_t;

   typedef struct {
      int                  ch;
      logic [CODE_W-1:0]   code;
      logic [SAMPLE_W-1:0] sr;
      int                  lat;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   ov_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (overrun === 1'b1) ov_cnt++;
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("out_valid unexpected", 32'(out_valid), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("out_chan", 32'(out_chan), 32'(mon_e.ch));
            check("out_data", 32'(out_data), 32'(mon_e.sr));
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic write(input int ch, input logic [CODE_W-1:0] c);
      ch_wr   = 1'b1;
      ch_idx  = CW'(ch);
      ch_code = c;
      tick();
      ch_wr   = 1'b0;
   endtask

   task automatic wait_start();
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (dec_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) check("dec_start wait expired", 32'(dec_start), 32'd1);
   endtask

   task automatic check_start(input int ch, input logic [CODE_W-1:0] c);
      check("dec_chan", 32'(dec_chan), 32'(ch));
      check("dec_code", 32'(dec_code), 32'(c));
   endtask

   task automatic finish_txn(input int ch, input logic [SAMPLE_W-1:0] sr);
      dec_done = 1'b1;
      dec_sr   = sr;
      sb.push_back(exp_t'{ch: CW'(ch), sr: sr});
      tick();
      dec_done = 1'b0;
      dec_sr   = 16'h0;
      check("out_valid after done", 32'(out_valid), 32'd1);
      check("dec_chan held in DONE", 32'(dec_chan), 32'(ch));
   endtask

   task automatic serve(input int ch, input logic [CODE_W-1:0] c, input logic [SAMPLE_W-1:0] sr);
      wait_start();
      check_start(ch, c);
      tick();
      finish_txn(ch, sr);
   endtask

   task automatic expect_quiet(input string name, input int n);
      int starts = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (dec_start === 1'b1) starts++;
      end
      check(name, 32'(starts), 32'd0);
   endtask

   vec_t vecs[5];
   int   ov0;
   int   seen;

   initial begin
      reset = 1'b1; ch_wr = 1'b0; ch_idx = '0; ch_code = '0; dec_done = 1'b0; dec_sr = '0;
      tick(3);
      reset = 1'b0;
      tick();
      check("reset dec_start", 32'(dec_start), 0);
      check("reset dec_chan", 32'(dec_chan), 0);
      check("reset dec_code", 32'(dec_code), 0);
      check("reset out_valid", 32'(out_valid), 0);
      check("reset out_chan", 32'(out_chan), 0);
      check("reset out_data", 32'(out_data), 0);
      check("reset overrun", 32'(overrun), 0);
      check("reset busy", 32'(busy), 0);
      check("reset timeout_err", 32'(timeout_err), 0);

      vecs[0] = '{ch: 5,  code: 4'hA, sr: 16'h1234, lat: 1};
      vecs[1] = '{ch: 0,  code: 4'h3, sr: 16'hBEEF, lat: 3};
      vecs[2] = '{ch: 31, code: 4'hF, sr: 16'h8001, lat: 2};
      vecs[3] = '{ch: 17, code: 4'h0, sr: 16'h0000, lat: 1};
      vecs[4] = '{ch: 1,  code: 4'h5, sr: 16'h7FFF, lat: 4};
      for (int v = 0; v < 5; v++) begin
         write(vecs[v].ch, vecs[v].code);
         check("no start in capture cycle", 32'(dec_start), 0);
         check("busy in capture cycle", 32'(busy), 0);
         tick();
         check("dec_start two cycles after write", 32'(dec_start), 1);
         check_start(vecs[v].ch, vecs[v].code);
         tick(vecs[v].lat);
         check("busy in WAIT", 32'(busy), 1);
         finish_txn(vecs[v].ch, vecs[v].sr);
         tick();
         check("idle after DONE", 32'(busy), 0);
      end
      tick(3);
      check("out_data holds", 32'(out_data), 32'(vecs[4].sr));
      check("out_chan holds", 32'(out_chan), 32'(vecs[4].ch));

      // last becomes 3, then 0/3/31 pend during its WAIT: order 31, 0, 3
      write(3, 4'h6);
      wait_start();
      check_start(3, 4'h6);
      tick();
      write(0, 4'h1);
      write(3, 4'h2);
      write(31, 4'h9);
      finish_txn(3, 16'h0303);
      serve(31, 4'h9, 16'h3131);
      serve(0, 4'h1, 16'h0000);
      serve(3, 4'h2, 16'h0033);
      expect_quiet("no start after rr drain", 6);

      ov0 = ov_cnt;
      write(2, 4'hC);
      wait_start();
      check_start(2, 4'hC);
      tick();
      write(7, 4'h1);
      write(7, 4'h2);
      tick();
      check("single overrun on ch7 rewrite", 32'(ov_cnt - ov0), 1);
      finish_txn(2, 16'h2222);
      serve(7, 4'h2, 16'h7777);
      expect_quiet("ch7 served once", 6);
      check("idle after ch7", 32'(busy), 0);

      // rewrite in the capture cycle: old code served, channel re-pended, no overrun
      ov0 = ov_cnt;
      write(4, 4'h6);
      write(4, 4'h8);
      check("start after capture-cycle write", 32'(dec_start), 1);
      check_start(4, 4'h6);
      tick();
      finish_txn(4, 16'h4444);
      serve(4, 4'h8, 16'h4848);
      tick(2);
      check("no overrun on capture-cycle write", 32'(ov_cnt - ov0), 0);

      write(9, 4'h3);
      wait_start();
      check_start(9, 4'h3);
      tick();
      write(9, 4'h4);
      finish_txn(9, 16'h0909);
      serve(9, 4'h4, 16'h9999);
      expect_quiet("no start after ch9", 4);

      write(12, 4'h5);
      wait_start();
      check_start(12, 4'h5);
      tick(2);
      write(20, 4'h7);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid reset dec_start", 32'(dec_start), 0);
      check("mid reset dec_chan", 32'(dec_chan), 0);
      check("mid reset dec_code", 32'(dec_code), 0);
      check("mid reset out_chan", 32'(out_chan), 0);
      check("mid reset out_data", 32'(out_data), 0);
      check("mid reset busy", 32'(busy), 0);
      dec_done = 1'b1;
      dec_sr   = 16'hDEAD;
      tick();
      dec_done = 1'b0;
      check("late done ignored", 32'(out_valid), 0);
      expect_quiet("pending cleared by reset", 8);
      check("busy after reset", 32'(busy), 0);

`ifdef DEC_SCHED_TIMEOUT_EN
      write(6, 4'h1);
      wait_start();
      check_start(6, 4'h1);
      seen = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (timeout_err === 1'b1) begin
            seen = i;
            break;
         end
      end
      check("timeout_err after 8 WAIT cycles", 32'(seen), 8);
      tick();
      check("busy low after timeout", 32'(busy), 0);
      check("timeout_err one pulse", 32'(timeout_err), 0);
      expect_quiet("aborted channel not re-pended", 6);
`endif

      tick(2);
      check("scoreboard drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
